// File: rtl/button_event_classifier_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
// Shared types for the push-button event classifier:
//   state_e  - classifier FSM states
//   event_e  - encoding of the one-cycle event reported on the outputs
//   max_ticks() - helper used to size the tick counter
// -----------------------------------------------------------------------------
package button_pkg;

  typedef enum logic [2:0] {
    ST_IDLE           = 3'd0,
    ST_PRESSED        = 3'd1,
    ST_LONG_HELD      = 3'd2,
    ST_WAIT_SECOND    = 3'd3,
    ST_SECOND_PRESSED = 3'd4
  } state_e;

  // A single registered event code keeps the three pulses mutually exclusive.
  typedef enum logic [1:0] {
    EV_NONE   = 2'd0,
    EV_SHORT  = 2'd1,
    EV_LONG   = 2'd2,
    EV_DOUBLE = 2'd3
  } event_e;

  function automatic int unsigned max_ticks(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_event_classifier_edge_detector.sv
// -----------------------------------------------------------------------------
// edge_detector
// Registers the previous level of a synchronous input and reports rising and
// falling edges combinationally against it. The reset value of the stored
// level is a parameter so a level that is already high at reset release can
// be kept from looking like a rising edge.
// Ports:
//   clk     in  system clock, rising edge
//   rst_n   in  asynchronous active-low reset
//   i_level in  synchronous level to watch
//   o_rise  out high while i_level = 1 and previous level = 0
//   o_fall  out high while i_level = 0 and previous level = 1
// -----------------------------------------------------------------------------
module edge_detector #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= RESET_VAL;
    end else begin
      r_prev <= i_level;
    end
  end

  assign o_rise = i_level & ~r_prev;
  assign o_fall = ~i_level & r_prev;

endmodule

// File: rtl/button_event_classifier.sv
// -----------------------------------------------------------------------------
// button_event_classifier
// Classifies debounced button presses into short, long and double presses,
// timing everything in ticks of the slow tickEnable strobe.
// Optional feature macro: DOUBLE_PRESS_EN
//   defined   - double-press detection; a short press is reported only after
//               GAP_TICKS with no second press
//   undefined - shortPress fires on release, doublePress tied 0
// Parameters:
//   LONG_TICKS  ticks held before a press is long (>= 2)
//   GAP_TICKS   ticks after release that a second press may start (>= 2)
// Ports:
//   masterClk   in  system clock, rising edge
//   resetN      in  asynchronous active-low reset
//   tickEnable  in  single-cycle timing strobe
//   buttonIn    in  debounced, synchronous button level
//   shortPress  out one-cycle pulse, short press
//   longPress   out one-cycle pulse, hold reached LONG_TICKS
//   doublePress out one-cycle pulse, double press
//   pressActive out level, FSM considers the button held
// -----------------------------------------------------------------------------
module button_event_classifier
  import button_pkg::*;
#(
  parameter int unsigned LONG_TICKS = 500,
  parameter int unsigned GAP_TICKS  = 250
) (
  input  logic masterClk,
  input  logic resetN,
  input  logic tickEnable,
  input  logic buttonIn,
  output logic shortPress,
  output logic longPress,
  output logic doublePress,
  output logic pressActive
);

  localparam int unsigned     MAX_TICKS = max_ticks(LONG_TICKS, GAP_TICKS);
  localparam int unsigned     CNT_W     = $clog2(MAX_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
`ifdef DOUBLE_PRESS_EN
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);
`endif

  logic             w_rise;
  logic             w_fall;
  logic             w_long_done;
  state_e           r_state;
  event_e           r_event;
  logic             r_press_active;
  logic [CNT_W-1:0] r_cnt;

  // Previous level resets high: a button held through reset must be released
  // and pressed again before it counts.
  edge_detector #(
    .RESET_VAL (1'b1)
  ) u_edge (
    .clk     (masterClk),
    .rst_n   (resetN),
    .i_level (buttonIn),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_long_done = tickEnable && (r_cnt == LONG_LAST);

  // Edges are tested before ticks in every state, so an edge coinciding with
  // a tick clears the counter and that tick is not counted. The counter is
  // held at zero in IDLE and LONG_HELD, where no threshold applies, so it
  // can never wrap.
  always_ff @(posedge masterClk or negedge resetN) begin
    if (!resetN) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_event        <= EV_NONE;
      r_press_active <= 1'b0;
    end else begin
      r_event <= EV_NONE;
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_state        <= ST_PRESSED;
            r_cnt          <= '0;
            r_press_active <= 1'b1;
          end
        end

        ST_PRESSED: begin
          if (w_fall) begin
`ifdef DOUBLE_PRESS_EN
            r_state        <= ST_WAIT_SECOND;
`else
            r_state        <= ST_IDLE;
            r_event        <= EV_SHORT;
`endif
            r_cnt          <= '0;
            r_press_active <= 1'b0;
          end else if (w_long_done) begin
            r_state <= ST_LONG_HELD;
            r_event <= EV_LONG;
            r_cnt   <= '0;
          end else if (tickEnable) begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        ST_LONG_HELD: begin
          if (w_fall) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_press_active <= 1'b0;
          end
        end

`ifdef DOUBLE_PRESS_EN
        ST_WAIT_SECOND: begin
          if (w_rise) begin
            r_state        <= ST_SECOND_PRESSED;
            r_cnt          <= '0;
            r_press_active <= 1'b1;
          end else if (tickEnable && (r_cnt == GAP_LAST)) begin
            r_state <= ST_IDLE;
            r_event <= EV_SHORT;
            r_cnt   <= '0;
          end else if (tickEnable) begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        // A long hold on the second click discards the first click.
        ST_SECOND_PRESSED: begin
          if (w_fall) begin
            r_state        <= ST_IDLE;
            r_event        <= EV_DOUBLE;
            r_cnt          <= '0;
            r_press_active <= 1'b0;
          end else if (w_long_done) begin
            r_state <= ST_LONG_HELD;
            r_event <= EV_LONG;
            r_cnt   <= '0;
          end else if (tickEnable) begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
`endif

        default: begin
          r_state        <= ST_IDLE;
          r_cnt          <= '0;
          r_press_active <= 1'b0;
        end
      endcase
    end
  end

  assign shortPress  = (r_event == EV_SHORT);
  assign longPress   = (r_event == EV_LONG);
`ifdef DOUBLE_PRESS_EN
  assign doublePress = (r_event == EV_DOUBLE);
`else
  assign doublePress = 1'b0;
`endif
  assign pressActive = r_press_active;

endmodule

// File: tb/tb_button_event_classifier.sv
// -----------------------------------------------------------------------------
// tb_button_event_classifier
// Directed bench for button_event_classifier with LONG_TICKS=8, GAP_TICKS=4
// and a tickEnable strobe every 10 cycles. Expected timings follow the
// DOUBLE_PRESS_EN setting the bench is compiled with.
// -----------------------------------------------------------------------------
module tb_button_event_classifier;

  localparam int unsigned LONG_T   = 8;
  localparam int unsigned GAP_T    = 4;
  localparam int unsigned TICK_PER = 10;

  logic masterClk;
  logic resetN;
  logic tickEnable;
  logic buttonIn;
  logic shortPress;
  logic longPress;
  logic doublePress;
  logic pressActive;

  int unsigned n_vec;
  int unsigned n_err;
  int unsigned cyc;
  int unsigned ph;
  int unsigned n_short, n_long, n_double;
  int unsigned t_short, t_long, t_double;
  int unsigned n_inactive;
  int unsigned t_mark;

  button_event_classifier #(
    .LONG_TICKS (LONG_T),
    .GAP_TICKS  (GAP_T)
  ) dut (
    .masterClk   (masterClk),
    .resetN      (resetN),
    .tickEnable  (tickEnable),
    .buttonIn    (buttonIn),
    .shortPress  (shortPress),
    .longPress   (longPress),
    .doublePress (doublePress),
    .pressActive (pressActive)
  );

  initial begin
    masterClk = 1'b0;
    forever #5 masterClk = ~masterClk;
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, sample outputs 1 time unit after the edge.
  task automatic run(input logic btn);
    buttonIn   = btn;
    tickEnable = (ph == 0);
    @(posedge masterClk);
    #1;
    cyc++;
    ph = (ph + 1) % TICK_PER;
    if (shortPress)  begin n_short++;  t_short  = cyc; end
    if (longPress)   begin n_long++;   t_long   = cyc; end
    if (doublePress) begin n_double++; t_double = cyc; end
    if (btn && !pressActive) n_inactive++;
  endtask

  task automatic run_n(input logic btn, input int unsigned n);
    repeat (n) run(btn);
  endtask

  task automatic sync_to(input int unsigned p);
    while (ph != p) run(1'b0);
  endtask

  task automatic clear_counts();
    n_short = 0; n_long = 0; n_double = 0;
    t_short = 0; t_long = 0; t_double = 0;
    n_inactive = 0;
  endtask

  task automatic do_reset(input logic btn);
    resetN     = 1'b0;
    buttonIn   = btn;
    tickEnable = 1'b0;
    repeat (3) @(posedge masterClk);
    @(negedge masterClk);
    resetN = 1'b1;
  endtask

  // 3-tick press then a long idle; short pulse timing depends on the build.
  task automatic short_press_case(input string tag);
    int unsigned fall;
    clear_counts();
    sync_to(1);
    run_n(1'b1, 30);
    run(1'b0);
    fall = cyc;
    check({tag, "_pa_after_fall"}, pressActive, 0);
    run_n(1'b0, 100);
    check({tag, "_n_short"}, n_short, 1);
    check({tag, "_n_long"}, n_long, 0);
    check({tag, "_n_double"}, n_double, 0);
`ifdef DOUBLE_PRESS_EN
    check({tag, "_t_short"}, t_short, fall + 39);
`else
    check({tag, "_t_short"}, t_short, fall);
`endif
  endtask

  initial begin
    int unsigned rise;
    int unsigned fall2;
    n_vec = 0; n_err = 0; cyc = 0; ph = 0;
    clear_counts();
    buttonIn = 1'b0; tickEnable = 1'b0; resetN = 1'b0;
    #1;
    check("rst_short", shortPress, 0);
    check("rst_long", longPress, 0);
    check("rst_double", doublePress, 0);
    check("rst_pa", pressActive, 0);
    do_reset(1'b0);

    // Short press
    short_press_case("short");

    // Two quick presses
    clear_counts();
    sync_to(1);
    run_n(1'b1, 30);
    run(1'b0);
    t_mark = cyc;
    run_n(1'b0, 19);
    run_n(1'b1, 20);
    run(1'b0);
    fall2 = cyc;
    run_n(1'b0, 100);
    check("dbl_n_long", n_long, 0);
`ifdef DOUBLE_PRESS_EN
    check("dbl_n_double", n_double, 1);
    check("dbl_t_double", t_double, fall2);
    check("dbl_n_short", n_short, 0);
`else
    check("dbl_n_double", n_double, 0);
    check("dbl_n_short", n_short, 2);
    check("dbl_t_short", t_short, fall2);
`endif

    // Long hold, 12 ticks
    clear_counts();
    sync_to(1);
    run(1'b1);
    rise = cyc;
    check("long_pa_rise", pressActive, 1);
    run_n(1'b1, 119);
    check("long_pa_inactive", n_inactive, 0);
    check("long_n_long", n_long, 1);
    check("long_t_long", t_long, rise + 79);
    run(1'b0);
    check("long_pa_release", pressActive, 0);
    run_n(1'b0, 100);
    check("long_n_short", n_short, 0);
    check("long_n_double", n_double, 0);
    check("long_n_long_end", n_long, 1);

    // Rise coincident with a tick
    clear_counts();
    sync_to(0);
    run(1'b1);
    rise = cyc;
    run_n(1'b1, 99);
    check("coinc_n_long", n_long, 1);
    check("coinc_t_long", t_long, rise + 80);
    run_n(1'b0, 100);
    check("coinc_n_short", n_short, 0);

    // Button held through reset release
    clear_counts();
    do_reset(1'b1);
    run_n(1'b1, 200);
    check("held_pa", pressActive, 0);
    run_n(1'b0, 100);
    check("held_n_short", n_short, 0);
    check("held_n_long", n_long, 0);
    check("held_n_double", n_double, 0);
    short_press_case("after_held");

    // Reset asserted mid-press
    clear_counts();
    sync_to(1);
    run_n(1'b1, 30);
    check("mid_pa_before", pressActive, 1);
    resetN = 1'b0;
    #1;
    check("mid_pa_async", pressActive, 0);
    check("mid_short_async", shortPress, 0);
    check("mid_long_async", longPress, 0);
    repeat (2) @(posedge masterClk);
    @(negedge masterClk);
    resetN = 1'b1;
    run_n(1'b1, 20);
    run_n(1'b0, 100);
    check("mid_n_short", n_short, 0);
    check("mid_n_long", n_long, 0);
    check("mid_n_double", n_double, 0);
    check("mid_pa_end", pressActive, 0);
    short_press_case("after_mid");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
